// File: rtl/pic_loader.sv
// pic_loader: write side of the picture window.
// Fills a single-port picture RAM, row-major, with a pichsize x picvsize image
// taken from a valid/ready pixel stream. The stream is stalled whenever the
// display holds the RAM port (rd_en).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: begin / restart a picture load
//   rd_en             display owns the RAM port this cycle
//   s_valid/s_ready   pixel stream handshake
//   s_data, s_eol     pixel value, last-pixel-of-row marker
//   wr_en/addr/data   registered RAM write port (1-cycle latency)
//   busy              high while loading
//   done              one-cycle completion pulse, with the final write
//   line_err          sticky row-alignment error (early or missing eol)
module pic_loader #(
  parameter int unsigned pichsize = 100,
  parameter int unsigned picvsize = 100,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned ADDR_W   = $clog2(pichsize * picvsize)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rd_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_eol,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              line_err
);

  localparam int unsigned X_W = (pichsize > 1) ? $clog2(pichsize) : 1;
  localparam int unsigned Y_W = (picvsize > 1) ? $clog2(picvsize) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(pichsize - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(picvsize - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t state, state_nxt;

  logic [X_W-1:0]    x, x_nxt;
  logic [Y_W-1:0]    y, y_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;

  logic accept;
  logic row_end;
  logic last_px;
  logic align_err;

  // A handshake coinciding with start is dropped: restart wins.
  assign accept    = (state == LOAD) && s_valid && !rd_en && !start;
  assign row_end   = (x == X_LAST) || s_eol;
  assign last_px   = accept && (y == Y_LAST) && row_end;
  // Missing eol at the row end, or eol before the row end.
  assign align_err = (x == X_LAST) ? !s_eol : s_eol;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (start)        state_nxt = LOAD;
        else if (last_px) state_nxt = DONE;
      end
      DONE: state_nxt = start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic (stream side follows the state directly)
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    if (state == LOAD) begin
      s_ready = !rd_en;
      busy    = 1'b1;
    end
  end

  // Address advance; early eol jumps to the next row start without a multiply.
  always_comb begin
    x_nxt    = x + X_W'(1);
    y_nxt    = y;
    addr_nxt = addr + ADDR_W'(1);
    if (x == X_LAST) begin
      x_nxt = '0;
      y_nxt = y + Y_W'(1);
    end else if (s_eol) begin
      x_nxt    = '0;
      y_nxt    = y + Y_W'(1);
      addr_nxt = addr + (ADDR_W'(pichsize) - ADDR_W'(x));
    end
  end

  // Counters, error flag and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      line_err <= 1'b0;
    end else begin
      wr_en <= accept;
      done  <= last_px;
      if (accept) begin
        wr_addr <= addr;
        wr_data <= s_data;
      end
      if (start) begin
        x        <= '0;
        y        <= '0;
        addr     <= '0;
        line_err <= 1'b0;
      end else begin
        // Final pixel leaves counters at their last position.
        if (accept && !last_px) begin
          x    <= x_nxt;
          y    <= y_nxt;
          addr <= addr_nxt;
        end
        if (accept && align_err) line_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pic_loader.sv
`timescale 1ns/1ps
module tb_pic_loader;

  localparam int unsigned HS = 100;
  localparam int unsigned VS = 100;
  localparam int unsigned DW = 12;
  localparam int unsigned AW = 14;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          rd_en;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_eol;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          line_err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_wr   = 0;
  int n_done = 0;

  pic_loader #(.pichsize(HS), .picvsize(VS), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rd_en   (rd_en),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_eol   (s_eol),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .line_err(line_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write must match the next expected entry in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        n_wr++;
        if (done) n_done++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: addr %0d data %0h done %0b", wr_addr, wr_data, done);
        end else begin
          e = sb.pop_front();
          if ({wr_addr, wr_data, done} !== e) begin
            n_err++;
            $display("FAIL write: got addr %0d data %0h done %0b expected addr %0d data %0h done %0b",
                     wr_addr, wr_data, done, e.addr, e.data, e.done);
          end
        end
      end else if (done) begin
        n_cmp++;
        n_err++;
        n_done++;
        $display("FAIL done_without_write: done=1 wr_en=0");
      end
    end
  end

  // Drives one picture; the bench tracks x/y itself and pushes y*HS+x.
  task automatic load_pic(input bit do_start, input bit rd_alt, input int early_row,
                          input bit miss_row0, input int stop_after);
    int x = 0;
    int y = 0;
    int idx = 0;
    bit last = 1'b0;
    bit rd = 1'b0;
    bit acc;
    bit eol;
    @(posedge clk); #1;
    if (do_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    while (!last && idx < stop_after) begin
      eol = ((y == early_row) && (x == 49)) ||
            ((x == HS - 1) && !(miss_row0 && (y == 0)));
      last = (y == VS - 1) && ((x == HS - 1) || eol);
      s_valid = 1'b1;
      s_data  = DW'(idx % 4096);
      s_eol   = eol;
      acc = 1'b0;
      while (!acc) begin
        rd = rd_alt ? ~rd : 1'b0;
        rd_en = rd;
        #1;
        acc = !rd;
        check("s_ready", 32'(s_ready), 32'(acc));
        if (acc) sb.push_back('{AW'(y * HS + x), DW'(idx % 4096), last});
        @(posedge clk); #1;
      end
      if (eol || x == HS - 1) begin
        x = 0;
        y++;
      end else begin
        x++;
      end
      idx++;
    end
    s_valid = 1'b0;
    s_eol   = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic finish_pic(input string name, input int w0, input int d0,
                            input int exp_wr, input bit exp_lerr);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_queue_left"}, 32'(sb.size()), 32'd0);
    check({name, "_writes"}, 32'(n_wr - w0), 32'(exp_wr));
    check({name, "_done_pulses"}, 32'(n_done - d0), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_line_err"}, 32'(line_err), 32'(exp_lerr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int d0;
    rst_n = 1'b0; start = 1'b0; rd_en = 1'b0;
    s_valid = 1'b0; s_data = '0; s_eol = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_line_err", 32'(line_err), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // Full clean picture, display idle
    w0 = n_wr; d0 = n_done;
    load_pic(1'b1, 1'b0, -1, 1'b0, BIG);
    finish_pic("clean", w0, d0, 10000, 1'b0);

    // Display reads on alternate cycles
    w0 = n_wr; d0 = n_done;
    load_pic(1'b1, 1'b1, -1, 1'b0, BIG);
    finish_pic("rd_alt", w0, d0, 10000, 1'b0);

    // Early eol at x=49 on row 3: next write at 400, 50 addresses skipped
    w0 = n_wr; d0 = n_done;
    load_pic(1'b1, 1'b0, 3, 1'b0, BIG);
    finish_pic("early_eol", w0, d0, 9950, 1'b1);

    // Missing eol on row 0, then restart after 5000 accepts
    load_pic(1'b1, 1'b0, -1, 1'b1, 5000);
    check("miss_eol_line_err", 32'(line_err), 1);
    start = 1'b1; s_valid = 1'b1; s_data = DW'(12'hABC); s_eol = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b0;
    check("restart_line_err", 32'(line_err), 0);
    check("restart_busy", 32'(busy), 1);
    w0 = n_wr; d0 = n_done;
    load_pic(1'b0, 1'b0, -1, 1'b0, BIG);
    finish_pic("restart", w0, d0, 10000, 1'b0);

    // Asynchronous reset mid-row with a write pending
    load_pic(1'b1, 1'b0, -1, 1'b0, 250);
    check("pre_rst_wr_en", 32'(wr_en), 1);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_wr_en", 32'(wr_en), 0);
    check("arst_s_ready", 32'(s_ready), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_s_ready", 32'(s_ready), 0);
    load_pic(1'b1, 1'b0, -1, 1'b0, 300);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_queue_left", 32'(sb.size()), 0);
    check("post_rst_busy_loading", 32'(busy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
